// File: rtl/mem_wb_stage.sv
// MEM stage of the five-stage MIPS pipeline: data memory (sync write, async read),
// sub-word load/store with W-stage store-data forwarding, and the MEM/WB register.
module mem_wb_stage #(
  parameter int DM_WORDS = 4096,
  parameter int DM_AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        in_rfwr,
  input  logic [4:0]  in_a3,
  input  logic [2:0]  in_tnew,
  input  logic [31:0] in_aluc,
  input  logic [31:0] in_rd2,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [1:0]  mem_size,
  input  logic        load_sign,
  input  logic        w_rfwr,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_data,
  output logic [31:0] m_fwd_data,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_rfwr,
  output logic [4:0]  out_a3,
  output logic [2:0]  out_tnew,
  output logic [31:0] out_wd,
  output logic        out_misalign
);

  logic [31:0]      dm [DM_WORDS];
  logic [DM_AW-1:0] idx;
  logic [31:0]      sd;
  logic [31:0]      rd_word;
  logic [31:0]      lane_data;
  logic [3:0]       be;
  logic [31:0]      st_word;
  logic             misaligned;
  logic             mis;
  logic [15:0]      ld_half;
  logic [7:0]       ld_byte;
  logic [31:0]      ld_val;
  logic [31:0]      wd;

  assign m_fwd_data = in_aluc;
  assign idx        = in_aluc[DM_AW+1:2];
  assign rd_word    = dm[idx];

  // W-stage result overrides stale rt data; $zero is never forwarded
  always_comb begin
    sd = in_rd2;
    if (w_rfwr && (w_a3 == in_instr[20:16]) && (w_a3 != 5'd0))
      sd = w_data;
  end

  always_comb begin
    case (mem_size)
      2'b01:   misaligned = in_aluc[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = |in_aluc[1:0];
    endcase
  end

  assign mis = (mem_wr | mem_rd) & misaligned;

  // Replicate the store data across lanes and merge only enabled bytes
  always_comb begin
    be        = 4'b1111;
    lane_data = sd;
    case (mem_size)
      2'b01: begin
        be        = in_aluc[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{sd[15:0]}};
      end
      2'b10: begin
        be        = 4'b0001 << in_aluc[1:0];
        lane_data = {4{sd[7:0]}};
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++)
      st_word[8*i +: 8] = be[i] ? lane_data[8*i +: 8] : rd_word[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++)
        dm[i] <= '0;
    end else if (mem_wr && !mis) begin
      dm[idx] <= st_word;
    end
  end

  always_comb begin
    ld_half = in_aluc[1] ? rd_word[31:16] : rd_word[15:0];
    case (in_aluc[1:0])
      2'b00:   ld_byte = rd_word[7:0];
      2'b01:   ld_byte = rd_word[15:8];
      2'b10:   ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    case (mem_size)
      2'b01:   ld_val = {{16{load_sign & ld_half[15]}}, ld_half};
      2'b10:   ld_val = {{24{load_sign & ld_byte[7]}}, ld_byte};
      default: ld_val = rd_word;
    endcase
    if (misaligned)
      ld_val = '0;
  end

  assign wd = mem_rd ? ld_val : in_aluc;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pc       <= '0;
      out_instr    <= '0;
      out_rfwr     <= 1'b0;
      out_a3       <= '0;
      out_tnew     <= '0;
      out_wd       <= '0;
      out_misalign <= 1'b0;
    end else begin
      out_pc       <= in_pc;
      out_instr    <= in_instr;
      out_rfwr     <= in_rfwr;
      out_a3       <= in_a3;
      out_tnew     <= (in_tnew == 3'd0) ? 3'd0 : in_tnew - 3'd1;
      out_wd       <= wd;
      out_misalign <= mis;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a reference memory model predicts each
// MEM/WB bundle when stimulus is driven; the bundle is compared one cycle later.
module tb_mem_wb_stage;
  localparam int DM_WORDS = 4096;
  localparam int DM_AW    = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_pc, in_instr, in_aluc, in_rd2, w_data;
  logic        in_rfwr, mem_wr, mem_rd, load_sign, w_rfwr;
  logic [4:0]  in_a3, w_a3;
  logic [2:0]  in_tnew;
  logic [1:0]  mem_size;
  logic [31:0] m_fwd_data, out_pc, out_instr, out_wd;
  logic        out_rfwr, out_misalign;
  logic [4:0]  out_a3;
  logic [2:0]  out_tnew;

  mem_wb_stage #(.DM_WORDS(DM_WORDS), .DM_AW(DM_AW)) dut (
    .clk(clk), .reset(reset), .in_pc(in_pc), .in_instr(in_instr), .in_rfwr(in_rfwr),
    .in_a3(in_a3), .in_tnew(in_tnew), .in_aluc(in_aluc), .in_rd2(in_rd2),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_size(mem_size), .load_sign(load_sign),
    .w_rfwr(w_rfwr), .w_a3(w_a3), .w_data(w_data), .m_fwd_data(m_fwd_data),
    .out_pc(out_pc), .out_instr(out_instr), .out_rfwr(out_rfwr), .out_a3(out_a3),
    .out_tnew(out_tnew), .out_wd(out_wd), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rfwr;
    logic [4:0]  a3;
    logic [2:0]  tnew;
    logic [31:0] wd;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [DM_WORDS];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] pc_ctr = 32'h0040_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic mis_f(input logic wr, input logic rd, input logic [1:0] sz,
                                 input logic [31:0] addr);
    logic m;
    case (sz)
      2'b01:   m = addr[0];
      2'b10:   m = 1'b0;
      default: m = (addr[1:0] != 2'b00);
    endcase
    return (wr | rd) & m;
  endfunction

  function automatic logic [31:0] load_f(input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] addr);
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = ref_mem[addr[DM_AW+1:2]];
    if (mis_f(1'b0, 1'b1, sz, addr)) return 32'h0;
    h = addr[1] ? w[31:16] : w[15:0];
    b = w[addr[1:0]*8 +: 8];
    case (sz)
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      2'b10:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
      default: return w;
    endcase
  endfunction

  task automatic store_model(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] sd);
    logic [31:0] w;
    w = ref_mem[addr[DM_AW+1:2]];
    case (sz)
      2'b01: if (addr[1]) w[31:16] = sd[15:0]; else w[15:0] = sd[15:0];
      2'b10: w[addr[1:0]*8 +: 8] = sd[7:0];
      default: w = sd;
    endcase
    ref_mem[addr[DM_AW+1:2]] = w;
  endtask

  task automatic op(input logic wr, input logic rd, input logic [1:0] sz, input logic sgn,
                    input logic [31:0] addr, input logic [31:0] data, input logic [2:0] tnew);
    exp_t        e;
    exp_t        g;
    logic [31:0] sd;
    in_pc     = pc_ctr;
    pc_ctr    = pc_ctr + 32'd4;
    in_instr  = 32'hAC05_0000 | {16'h0, pc_ctr[15:0]};
    in_rfwr   = rd;
    in_a3     = 5'($urandom_range(0, 31));
    in_tnew   = tnew;
    in_aluc   = addr;
    in_rd2    = data;
    mem_wr    = wr;
    mem_rd    = rd;
    mem_size  = sz;
    load_sign = sgn;
    #1;
    check("m_fwd", m_fwd_data, addr);
    sd = (w_rfwr && w_a3 == in_instr[20:16] && w_a3 != 5'd0) ? w_data : data;
    e.pc    = in_pc;
    e.instr = in_instr;
    e.rfwr  = in_rfwr;
    e.a3    = in_a3;
    e.tnew  = (tnew == 3'd0) ? 3'd0 : tnew - 3'd1;
    e.mis   = mis_f(wr, rd, sz, addr);
    e.wd    = rd ? load_f(sz, sgn, addr) : addr;
    sb_q.push_back(e);
    if (wr && !e.mis) store_model(sz, addr, sd);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      check("pc", out_pc, g.pc);
      check("instr", out_instr, g.instr);
      check("rfwr", {31'h0, out_rfwr}, {31'h0, g.rfwr});
      check("a3", {27'h0, out_a3}, {27'h0, g.a3});
      check("tnew", {29'h0, out_tnew}, {29'h0, g.tnew});
      check("wd", out_wd, g.wd);
      check("mis", {31'h0, out_misalign}, {31'h0, g.mis});
    end
  endtask

  // Reset with a store presented in the same cycle; the store must be dropped
  task automatic do_reset();
    reset    = 1'b1;
    mem_wr   = 1'b1;
    mem_rd   = 1'b0;
    mem_size = 2'b00;
    in_aluc  = 32'h10;
    in_rd2   = 32'hFFFF_FFFF;
    in_pc    = 32'hFFFF_FFF0;
    in_instr = 32'hAC05_0000;
    in_rfwr  = 1'b1;
    in_a3    = 5'd7;
    in_tnew  = 3'd5;
    @(posedge clk);
    #1;
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_rfwr", {31'h0, out_rfwr}, 32'h0);
    check("rst_a3", {27'h0, out_a3}, 32'h0);
    check("rst_tnew", {29'h0, out_tnew}, 32'h0);
    check("rst_wd", out_wd, 32'h0);
    check("rst_mis", {31'h0, out_misalign}, 32'h0);
    check("rst_mfwd", m_fwd_data, 32'h10);
    for (int i = 0; i < DM_WORDS; i++) ref_mem[i] = 32'h0;
    reset  = 1'b0;
    mem_wr = 1'b0;
  endtask

  initial begin
    w_rfwr    = 1'b0;
    w_a3      = 5'd0;
    w_data    = 32'h0;
    load_sign = 1'b0;
    do_reset();

    op(1, 0, 2'b00, 0, 32'h10, 32'h1234_5678, 3'd1);
    op(0, 1, 2'b00, 0, 32'h10, 32'h0, 3'd1);
    check("lw_10", out_wd, 32'h1234_5678);

    op(1, 0, 2'b10, 0, 32'h13, 32'h0000_00AB, 3'd0);
    op(0, 1, 2'b00, 0, 32'h10, 32'h0, 3'd1);
    check("lw_after_sb", out_wd, 32'hAB34_5678);
    op(0, 1, 2'b10, 1, 32'h13, 32'h0, 3'd1);
    check("lb_13", out_wd, 32'hFFFF_FFAB);
    op(0, 1, 2'b10, 0, 32'h13, 32'h0, 3'd1);
    check("lbu_13", out_wd, 32'h0000_00AB);

    op(1, 0, 2'b01, 0, 32'h22, 32'h0000_8001, 3'd0);
    op(0, 1, 2'b01, 1, 32'h22, 32'h0, 3'd1);
    check("lh_22", out_wd, 32'hFFFF_8001);
    op(0, 1, 2'b01, 0, 32'h22, 32'h0, 3'd1);
    check("lhu_22", out_wd, 32'h0000_8001);
    op(0, 1, 2'b00, 0, 32'h20, 32'h0, 3'd1);
    check("lw_20", out_wd, 32'h8001_0000);

    w_rfwr = 1'b1; w_a3 = 5'd5; w_data = 32'hDEAD_BEEF;
    op(1, 0, 2'b00, 0, 32'h30, 32'h1, 3'd0);
    w_a3 = 5'd0;
    op(1, 0, 2'b00, 0, 32'h34, 32'h1, 3'd0);
    w_rfwr = 1'b0;
    op(0, 1, 2'b00, 0, 32'h30, 32'h0, 3'd1);
    check("fwd_w5", out_wd, 32'hDEAD_BEEF);
    op(0, 1, 2'b00, 0, 32'h34, 32'h0, 3'd1);
    check("fwd_w0", out_wd, 32'h1);

    op(1, 0, 2'b00, 0, 32'h11, 32'h5555_5555, 3'd2);
    check("sw_mis", {31'h0, out_misalign}, 32'h1);
    check("tnew_2", {29'h0, out_tnew}, 32'h1);
    op(0, 1, 2'b00, 0, 32'h10, 32'h0, 3'd0);
    check("mis_clear", {31'h0, out_misalign}, 32'h0);
    check("tnew_0", {29'h0, out_tnew}, 32'h0);
    check("sw_mis_mem", out_wd, 32'hAB34_5678);

    op(0, 1, 2'b00, 0, DM_WORDS * 4 + 32'h10, 32'h0, 3'd1);
    check("alias_ld", out_wd, 32'hAB34_5678);
    op(1, 0, 2'b00, 0, DM_WORDS * 4 + 32'h14, 32'hCAFE_F00D, 3'd1);
    op(0, 1, 2'b00, 0, 32'h14, 32'h0, 3'd1);
    check("alias_st", out_wd, 32'hCAFE_F00D);

    for (int i = 0; i < 80; i++) begin
      logic wr, rd;
      wr     = 1'($urandom_range(0, 1));
      rd     = wr ? 1'b0 : 1'($urandom_range(0, 1));
      w_rfwr = 1'($urandom_range(0, 1));
      w_a3   = 5'($urandom_range(0, 7));
      w_data = $urandom;
      op(wr, rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         $urandom & 32'hFFFF_C03F, $urandom, 3'($urandom_range(0, 7)));
    end
    w_rfwr = 1'b0;

    do_reset();
    op(0, 1, 2'b00, 0, 32'h10, 32'h0, 3'd1);
    check("rst_drop_st", out_wd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage of the five-stage pipelined MIPS core; sits directly downstream of the EX/MEM register and consumes its outputs.
- Holds the data memory: synchronous write, asynchronous read. Performs word, half and byte stores and loads; forwards W-stage results into store data.
- Registers the writeback bundle into the MEM/WB pipeline register that drives the register-file write port and the W-stage forwarding network.

Parameters:
DM_WORDS, 4096, data memory depth in 32-bit words. Must be a power of two; address wraps modulo depth.
DM_AW, 12, word-index width, equal to log2(DM_WORDS).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_pc  in  32  PC of the instruction in MEM
in_instr  in  32  instruction word; rt is bits [20:16]
in_rfwr  in  1  instruction writes the register file
in_a3  in  5  destination register
in_tnew  in  3  cycles until result is ready
in_aluc  in  32  ALU result; this is the byte address for memory ops
in_rd2  in  32  store data before W forwarding
mem_wr  in  1  store instruction
mem_rd  in  1  load instruction
mem_size  in  2  00 word, 01 half, 10 byte, 11 treated as word
load_sign  in  1  sign-extend half/byte loads
w_rfwr  in  1  W-stage register write enable, for forwarding
w_a3  in  5  W-stage destination register
w_data  in  32  W-stage write data
m_fwd_data  out  32  combinational MEM-stage forward value, equal to in_aluc
out_pc  out  32  registered in_pc
out_instr  out  32  registered in_instr
out_rfwr  out  1  registered in_rfwr
out_a3  out  5  registered in_a3
out_tnew  out  3  registered in_tnew, decremented with saturation
out_wd  out  32  registered writeback data
out_misalign  out  1  registered flag: misaligned memory access

Behaviour:
- Reset (synchronous, active-high): all out_* clear to 0 and every data-memory word clears to 0.
  - A store presented in the same cycle as reset is dropped.
  - Reset does not affect m_fwd_data, which is combinational.
- Word index: in_aluc[DM_AW+1:2]. Upper address bits are ignored, so addresses wrap.
- Store-data forwarding:
  - sd = w_data when w_rfwr is 1, w_a3 == in_instr[20:16] and w_a3 != 0.
  - Otherwise sd = in_rd2.
- Alignment check:
  - word access is misaligned when in_aluc[1:0] != 0.
  - half access is misaligned when in_aluc[0] != 0.
  - byte access is never misaligned.
  - mis = (mem_wr or mem_rd) and misaligned.
- Store, at posedge clk when mem_wr is 1, reset is 0 and mis is 0:
  - word: whole word ← sd.
  - half: sd[15:0] written to bytes {1,0} when in_aluc[1] is 0, else to bytes {3,2}.
  - byte: sd[7:0] written to byte lane in_aluc[1:0].
  - Other lanes are preserved.
- Load (combinational read of the current word):
  - word: the word as read.
  - half: lane selected by in_aluc[1].
  - byte: lane selected by in_aluc[1:0].
  - half/byte are sign-extended when load_sign is 1, zero-extended otherwise.
  - A misaligned load yields 0.
- Little-endian lane numbering: byte 0 = bits [7:0].
- Writeback select: wd = load value when mem_rd is 1, else in_aluc.
- Pipeline register update at posedge when reset is 0:
  - out_pc/out_instr/out_rfwr/out_a3 ← inputs.
  - out_wd ← wd.
  - out_misalign ← mis.
  - out_tnew ← (in_tnew == 0) ? 0 : in_tnew − 1.
- Latency: one cycle from inputs to out_*. A store committed at edge N is visible to a load presented after edge N.
- mem_wr and mem_rd are never both 1. If they are, the store is performed and the load reads the pre-edge data.
- A misaligned store leaves memory unchanged; out_misalign is 1 for one cycle.

Test Plan:
- Reset, then store word 0x12345678 to addr 0x10 and load word from addr 0x10 next cycle → out_wd = 0x12345678 one cycle after the load.
- Store byte 0xAB to addr 0x13 over word 0x12345678 at 0x10, then load word 0x10 → 0xAB345678. lb at 0x13 → 0xFFFFFFAB; lbu at 0x13 → 0x000000AB.
- sh 0x8001 at addr 0x22, then lh at 0x22 → 0xFFFF8001; lhu at 0x22 → 0x00008001; lw at 0x20 → upper half 0x8001, lower half unchanged.
- Store word with in_rd2 = 0x1, w_rfwr = 1, w_a3 = rt = 5, w_data = 0xDEADBEEF → memory holds 0xDEADBEEF. Repeat with w_a3 = 0 → memory holds 0x1.
- sw at addr 0x11 → memory unchanged, out_misalign = 1 for one cycle. Also, in_tnew = 2 → out_tnew = 1; in_tnew = 0 → out_tnew = 0.
- Store issued in the same cycle as reset is asserted → memory word stays 0 and all out_* read 0 after the edge. An address of DM_WORDS*4 + 0x10 aliases addr 0x10.
